// File: rtl/pc_branch_unit.sv
// -----------------------------------------------------------------------------
// pc_branch_unit
//
// Purpose:
//   Next-PC generator and program-counter register for the single-issue core.
//   Resolves every RV32I conditional branch (signed and unsigned), JAL and
//   JALR directly from operand values. It holds the fetch PC across stalls and
//   keeps one pending redirect that arrives while fetch is stalled.
//
// Parameters:
//   XLEN     width of PC, operands and immediate
//   PC_INC   address increment per instruction (1 = word, 4 = byte addressed)
//   RESET_PC PC value loaded on reset
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset, overrides everything
//   stall        in   fetch must hold the current PC this cycle
//   halt         in   enter HALT, PC frozen until reset
//   br_valid     in   a branch/jump resolves this cycle
//   br_tipo      in   0 JAL,1 BEQ,2 BNE,3 BLT,4 BGE,5 BLTU,6 BGEU,7 JALR
//   br_pc        in   PC of the resolving instruction
//   rs1, rs2     in   operands
//   imed         in   sign-extended offset
//   pc           out  current fetch address
//   pc_valid     out  pc is a valid fetch address this cycle
//   taken        out  previous accepted branch was taken (registered)
//   link         out  br_pc + PC_INC, combinational return address
//   misalign     out  last taken target was not a multiple of PC_INC
//   o_dbg_state  out  current FSM state (BOOT=0, RUN=1, STALL=2, HALT=3)
//
// Optional feature (macro BRANCH_STATS_EN):
//   br_count        out  number of accepted br_valid cycles
//   br_taken_count  out  number of taken redirects
//   stall_cycles    out  number of cycles spent in STALL
//   All three reset to 0, saturate at 2^32-1 and freeze in HALT.
//
// Handshake:
//   There is no backpressure. A branch is accepted in the cycle br_valid is
//   high while the unit is in RUN or STALL and halt is low; in BOOT and HALT
//   br_valid is ignored. The fetch address on pc is meaningful only while
//   pc_valid is high.
// -----------------------------------------------------------------------------
module pc_branch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     PC_INC   = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt,
  input  logic            br_valid,
  input  logic [2:0]      br_tipo,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imed,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            taken,
  output logic [XLEN-1:0] link,
  output logic            misalign,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     br_count,
  output logic [31:0]     br_taken_count,
  output logic [31:0]     stall_cycles,
`endif
  output logic [1:0]      o_dbg_state
);

  localparam logic [XLEN-1:0] LP_INC = XLEN'(PC_INC);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [2:0] T_JAL  = 3'd0;
  localparam logic [2:0] T_BEQ  = 3'd1;
  localparam logic [2:0] T_BNE  = 3'd2;
  localparam logic [2:0] T_BLT  = 3'd3;
  localparam logic [2:0] T_BGE  = 3'd4;
  localparam logic [2:0] T_BLTU = 3'd5;
  localparam logic [2:0] T_BGEU = 3'd6;
  localparam logic [2:0] T_JALR = 3'd7;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_pc_valid;
  logic            r_taken;
  logic            r_misalign;
  logic            r_pend_v;
  logic [XLEN-1:0] r_pend;

  // ---------------------------------------------------------------------------
  // Condition evaluation straight from the operands
  // ---------------------------------------------------------------------------
  logic            w_eq;
  logic            w_lt;
  logic            w_ltu;
  logic            w_cond;

  assign w_eq  = (rs1 == rs2);
  assign w_lt  = ($signed(rs1) < $signed(rs2));
  assign w_ltu = (rs1 < rs2);

  always_comb begin
    w_cond = 1'b0;
    case (br_tipo)
      T_JAL:   w_cond = 1'b1;
      T_BEQ:   w_cond = w_eq;
      T_BNE:   w_cond = ~w_eq;
      T_BLT:   w_cond = w_lt;
      T_BGE:   w_cond = ~w_lt;
      T_BLTU:  w_cond = w_ltu;
      T_BGEU:  w_cond = ~w_ltu;
      T_JALR:  w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Target computation. All sums wrap modulo 2^XLEN.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] w_tgt_rel;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_target;
  logic            w_misal;
  logic [XLEN-1:0] w_seq_pc;

  assign w_tgt_rel  = br_pc + imed;
  assign w_jalr_sum = rs1 + imed;
  // JALR clears bit 0 of the sum (RISC-V semantics).
  assign w_target   = (br_tipo == T_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_tgt_rel;
  // With PC_INC = 1 every target is aligned, so misalign can never be set.
  assign w_misal    = ((w_target % LP_INC) != '0);
  assign w_seq_pc   = r_pc + LP_INC;

  // A branch only counts while the unit is actually fetching; a halt in the
  // same cycle wins and the branch is dropped.
  logic w_accept;
  logic w_redirect;

  assign w_accept   = br_valid & ~halt &
                      ((r_state == ST_RUN) | (r_state == ST_STALL));
  assign w_redirect = w_accept & w_cond;

  // ---------------------------------------------------------------------------
  // FSM and PC register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_pc_valid <= 1'b0;
      r_taken    <= 1'b0;
      r_misalign <= 1'b0;
      r_pend_v   <= 1'b0;
      r_pend     <= '0;
    end else begin
      case (r_state)
        // BOOT leaves pc at RESET_PC, so the reset vector is the first
        // address presented with pc_valid high.
        ST_BOOT: begin
          r_state    <= ST_RUN;
          r_pc_valid <= 1'b1;
        end

        ST_RUN, ST_STALL: begin
          if (halt) begin
            r_state    <= ST_HALT;
            r_pc_valid <= 1'b0;
            r_pend_v   <= 1'b0;
          end else begin
            if (w_accept) begin
              r_taken <= w_cond;
              if (w_cond) begin
                r_misalign <= w_misal;
              end
            end

            if (stall) begin
              // Hold pc; a redirect seen now is parked, youngest wins.
              r_state <= ST_STALL;
              if (w_redirect) begin
                r_pend_v <= 1'b1;
                r_pend   <= w_target;
              end
            end else begin
              // A redirect in this very cycle is younger than anything parked.
              r_state  <= ST_RUN;
              r_pend_v <= 1'b0;
              if (w_redirect) begin
                r_pc <= w_target;
              end else if (r_pend_v) begin
                r_pc <= r_pend;
              end else begin
                r_pc <= w_seq_pc;
              end
            end
          end
        end

        ST_HALT: begin
          r_state    <= ST_HALT;
          r_pc_valid <= 1'b0;
        end

        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  assign pc          = r_pc;
  assign pc_valid    = r_pc_valid;
  assign taken       = r_taken;
  assign misalign    = r_misalign;
  assign link        = br_pc + LP_INC;
  assign o_dbg_state = r_state;

`ifdef BRANCH_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters, saturating. Since w_accept is false in HALT and
  // r_state never reads STALL there, all three freeze once halted.
  // ---------------------------------------------------------------------------
  logic [31:0] r_br_count;
  logic [31:0] r_br_taken_count;
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_count       <= '0;
      r_br_taken_count <= '0;
      r_stall_cycles   <= '0;
    end else begin
      if (w_accept && (r_br_count != '1)) begin
        r_br_count <= r_br_count + 32'd1;
      end
      if (w_redirect && (r_br_taken_count != '1)) begin
        r_br_taken_count <= r_br_taken_count + 32'd1;
      end
      if ((r_state == ST_STALL) && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign br_count       = r_br_count;
  assign br_taken_count = r_br_taken_count;
  assign stall_cycles   = r_stall_cycles;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_branch_unit
//
// Two instances share one stimulus stream: dut_a (PC_INC=1, RESET_PC=0) and
// dut_b (PC_INC=4, RESET_PC=0x80). A reference model describes the unit in
// terms of "booted / halted / held / one parked target" and is checked on both
// instances every cycle. A directed vector table pins dut_a against hand
// computed values, a hand sequence covers the byte-addressed corner cases,
// and a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        halt;
  logic        br_valid;
  logic [2:0]  br_tipo;
  logic [31:0] br_pc;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] imed;

  logic [31:0] pc_a, link_a, pc_b, link_b;
  logic        pcv_a, tk_a, mis_a, pcv_b, tk_b, mis_b;
  logic [1:0]  dbg_a, dbg_b;
`ifdef BRANCH_STATS_EN
  logic [31:0] brc_a, tkc_a, stc_a, brc_b, tkc_b, stc_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------------------------------------------------------------------
  // Clock / DUTs
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  pc_branch_unit #(.XLEN(32), .PC_INC(1), .RESET_PC(32'h0)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .br_valid(br_valid),
    .br_tipo(br_tipo), .br_pc(br_pc), .rs1(rs1), .rs2(rs2), .imed(imed),
    .pc(pc_a), .pc_valid(pcv_a), .taken(tk_a), .link(link_a), .misalign(mis_a),
`ifdef BRANCH_STATS_EN
    .br_count(brc_a), .br_taken_count(tkc_a), .stall_cycles(stc_a),
`endif
    .o_dbg_state(dbg_a)
  );

  pc_branch_unit #(.XLEN(32), .PC_INC(4), .RESET_PC(32'h80)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .br_valid(br_valid),
    .br_tipo(br_tipo), .br_pc(br_pc), .rs1(rs1), .rs2(rs2), .imed(imed),
    .pc(pc_b), .pc_valid(pcv_b), .taken(tk_b), .link(link_b), .misalign(mis_b),
`ifdef BRANCH_STATS_EN
    .br_count(brc_b), .br_taken_count(tkc_b), .stall_cycles(stc_b),
`endif
    .o_dbg_state(dbg_b)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] inc [2] = '{32'd1, 32'd4};
  logic [31:0] rpc [2] = '{32'h0, 32'h80};

  bit          m_init   [2] = '{0, 0};
  bit          m_boot   [2];
  bit          m_halted [2];
  bit          m_held   [2];
  bit          m_pend_v [2];
  logic [31:0] m_pend   [2];
  logic [31:0] m_pc     [2];
  bit          m_taken  [2];
  bit          m_mis    [2];
  logic [31:0] m_brc    [2];
  logic [31:0] m_tkc    [2];
  logic [31:0] m_stc    [2];

  function automatic bit ref_cond(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      3'd1:    return a == b;
      3'd2:    return a != b;
      3'd3:    return $signed(a) < $signed(b);
      3'd4:    return $signed(a) >= $signed(b);
      3'd5:    return a < b;
      3'd6:    return a >= b;
      default: return 1'b1;  // JAL, JALR
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [2:0] t, input logic [31:0] p,
                                             input logic [31:0] a, input logic [31:0] imm);
    if (t == 3'd7) return (a + imm) & 32'hFFFF_FFFE;
    return p + imm;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_step(input int k);
    bit          c;
    logic [31:0] t;
    c = ref_cond(br_tipo, rs1, rs2);
    t = ref_target(br_tipo, br_pc, rs1, imed);
    if (rst) begin
      m_init[k] = 1; m_boot[k] = 1; m_halted[k] = 0; m_held[k] = 0;
      m_pend_v[k] = 0; m_pend[k] = 0; m_pc[k] = rpc[k];
      m_taken[k] = 0; m_mis[k] = 0;
      m_brc[k] = 0; m_tkc[k] = 0; m_stc[k] = 0;
    end else if (m_init[k] && !m_halted[k]) begin
      if (m_boot[k]) begin
        m_boot[k] = 0;
      end else begin
        if (m_held[k]) m_stc[k] = sat_inc(m_stc[k]);
        if (halt) begin
          m_halted[k] = 1;
        end else begin
          if (br_valid) begin
            m_brc[k]   = sat_inc(m_brc[k]);
            m_taken[k] = c;
            if (c) begin
              m_tkc[k] = sat_inc(m_tkc[k]);
              m_mis[k] = (t % inc[k]) != 0;
            end
          end
          if (stall) begin
            m_held[k] = 1;
            if (br_valid && c) begin
              m_pend_v[k] = 1;
              m_pend[k]   = t;
            end
          end else begin
            if (br_valid && c)    m_pc[k] = t;
            else if (m_pend_v[k]) m_pc[k] = m_pend[k];
            else                  m_pc[k] = m_pc[k] + inc[k];
            m_held[k]   = 0;
            m_pend_v[k] = 0;
          end
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      if (m_init[k]) begin
        chk($sformatf("m_pc[%0d]", k),    k ? pc_b  : pc_a,  m_pc[k]);
        chk($sformatf("m_valid[%0d]", k), 32'(k ? pcv_b : pcv_a),
            32'(!m_boot[k] && !m_halted[k]));
        chk($sformatf("m_taken[%0d]", k), 32'(k ? tk_b : tk_a), 32'(m_taken[k]));
        chk($sformatf("m_mis[%0d]", k),   32'(k ? mis_b : mis_a), 32'(m_mis[k]));
        chk($sformatf("m_link[%0d]", k),  k ? link_b : link_a, br_pc + inc[k]);
`ifdef BRANCH_STATS_EN
        chk($sformatf("m_brc[%0d]", k), k ? brc_b : brc_a, m_brc[k]);
        chk($sformatf("m_tkc[%0d]", k), k ? tkc_b : tkc_a, m_tkc[k]);
        chk($sformatf("m_stc[%0d]", k), k ? stc_b : stc_a, m_stc[k]);
`endif
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic s, input logic h, input logic bv, input logic [2:0] t,
                       input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm);
    stall = s; halt = h; br_valid = bv; br_tipo = t;
    br_pc = p; rs1 = a; rs2 = b; imed = imm;
  endtask

  task automatic idle();
    drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // One clock: model advances with the inputs seen at the edge, outputs are
  // sampled 1 time unit later while inputs are still stable.
  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_model();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table (expectations for dut_a, PC_INC=1, RESET_PC=0)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        s, h, bv;
    logic [2:0]  t;
    logic [31:0] p, a, b, imm;
    logic [31:0] e_pc;
    logic        e_valid, e_taken;
  } vec_t;

  vec_t vecs [22];

  initial begin
    vecs[0]  = '{0,0,0,3'd0, 32'd0,     32'd0,        32'd0,        32'd0,        32'd0,     1,0}; // BOOT->RUN
    vecs[1]  = '{0,0,0,3'd0, 32'd0,     32'd0,        32'd0,        32'd0,        32'd1,     1,0};
    vecs[2]  = '{0,0,0,3'd0, 32'd0,     32'd0,        32'd0,        32'd0,        32'd2,     1,0};
    vecs[3]  = '{0,0,0,3'd0, 32'd0,     32'd0,        32'd0,        32'd0,        32'd3,     1,0};
    vecs[4]  = '{0,0,1,3'd5, 32'd10,    32'h1,        32'hFFFF_FFFF,32'd8,        32'd18,    1,1}; // BLTU taken
    vecs[5]  = '{0,0,1,3'd3, 32'd10,    32'h1,        32'hFFFF_FFFF,32'd8,        32'd19,    1,0}; // BLT not
    vecs[6]  = '{0,0,1,3'd7, 32'h50,    32'h101,      32'd0,        32'd4,        32'h104,   1,1}; // JALR
    vecs[7]  = '{1,0,0,3'd0, 32'd0,     32'd0,        32'd0,        32'd0,        32'h104,   1,1}; // stall
    vecs[8]  = '{1,0,1,3'd1, 32'd20,    32'd5,        32'd5,        32'hFFFF_FFFC,32'h104,   1,1}; // BEQ parked
    vecs[9]  = '{1,0,0,3'd0, 32'd0,     32'd0,        32'd0,        32'd0,        32'h104,   1,1};
    vecs[10] = '{0,0,0,3'd0, 32'd0,     32'd0,        32'd0,        32'd0,        32'd16,    1,1}; // release
    vecs[11] = '{0,0,0,3'd0, 32'd0,     32'd0,        32'd0,        32'd0,        32'd17,    1,1}; // pend cleared
    vecs[12] = '{0,0,1,3'd2, 32'd30,    32'd5,        32'd5,        32'd2,        32'd18,    1,0}; // BNE not
    vecs[13] = '{0,0,1,3'd4, 32'd100,   32'hFFFF_FFFD,32'hFFFF_FFFD,32'hFFFF_FFCE,32'd50,    1,1}; // BGE eq
    vecs[14] = '{0,0,1,3'd6, 32'd100,   32'd2,        32'd3,        32'd8,        32'd51,    1,0}; // BGEU not
    vecs[15] = '{0,0,1,3'd0, 32'h200,   32'd0,        32'd0,        32'h10,       32'h210,   1,1}; // JAL
    vecs[16] = '{1,0,1,3'd1, 32'd0,     32'd4,        32'd4,        32'd8,        32'h210,   1,1}; // stall+br
    vecs[17] = '{0,0,1,3'd2, 32'h300,   32'd1,        32'd2,        32'd4,        32'h304,   1,1}; // youngest
    vecs[18] = '{0,0,0,3'd0, 32'd0,     32'd0,        32'd0,        32'd0,        32'h305,   1,1};
    vecs[19] = '{0,1,1,3'd2, 32'd0,     32'd7,        32'd7,        32'h40,       32'h305,   0,1}; // halt wins
    vecs[20] = '{0,0,0,3'd0, 32'd0,     32'd0,        32'd0,        32'd0,        32'h305,   0,1};
    vecs[21] = '{0,0,1,3'd1, 32'd0,     32'd3,        32'd3,        32'h40,       32'h305,   0,1}; // ignored
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    idle();
    cycle();
    cycle();
    chk("rst_pc_a",    pc_a,        32'h0);
    chk("rst_valid_a", 32'(pcv_a),  32'h0);
    chk("rst_taken_a", 32'(tk_a),   32'h0);
    chk("rst_mis_a",   32'(mis_a),  32'h0);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].s, vecs[i].h, vecs[i].bv, vecs[i].t,
            vecs[i].p, vecs[i].a, vecs[i].b, vecs[i].imm);
      cycle();
      chk($sformatf("vec%0d_pc", i),    pc_a,       vecs[i].e_pc);
      chk($sformatf("vec%0d_valid", i), 32'(pcv_a), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_taken", i), 32'(tk_a),  32'(vecs[i].e_taken));
      if (vecs[i].t == 3'd7 && vecs[i].bv)
        chk("jalr_link_a", link_a, 32'h51);
    end

    // Byte-addressed corner cases on dut_b (PC_INC=4, RESET_PC=0x80).
    rst = 1'b1; idle(); cycle();
    chk("b_rst_pc", pc_b, 32'h80);
    rst = 1'b0;
    cycle();
    chk("b_boot_pc", pc_b, 32'h80);
    chk("b_boot_valid", 32'(pcv_b), 32'h1);
    drive(0, 0, 1, 3'd0, 32'h100, 32'd0, 32'd0, 32'd6);       // JAL to 0x106
    cycle();
    chk("b_jal_pc", pc_b, 32'h106);
    chk("b_jal_mis", 32'(mis_b), 32'h1);
    drive(0, 0, 1, 3'd1, 32'h200, 32'd9, 32'd9, 32'd8);       // BEQ to 0x208
    cycle();
    chk("b_beq_pc", pc_b, 32'h208);
    chk("b_beq_mis", 32'(mis_b), 32'h0);
    drive(0, 0, 1, 3'd0, 32'h0, 32'd0, 32'd0, 32'hFFFF_FFFC); // JAL to top
    cycle();
    chk("b_top_pc", pc_b, 32'hFFFF_FFFC);
    idle(); cycle();
    chk("b_wrap_pc", pc_b, 32'h0);
    chk("a_wrap_pc", pc_a, 32'hFFFF_FFFD);
    drive(1, 0, 1, 3'd0, 32'h400, 32'd0, 32'd0, 32'h20);      // park 0x420
    cycle();
    chk("b_park_pc", pc_b, 32'h0);
    drive(1, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    rst = 1'b1;                                               // reset mid-stall
    cycle();
    chk("b_midrst_pc", pc_b, 32'h80);
    chk("b_midrst_valid", 32'(pcv_b), 32'h0);
    rst = 1'b0; idle(); cycle();
    chk("b_after_pc", pc_b, 32'h80);
    cycle();
    chk("b_after2_pc", pc_b, 32'h84);

    // Randomized phase, checked by the model every cycle.
    rst = 1'b1; idle(); cycle();
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 149) == 0);
      halt     = ($urandom_range(0, 199) == 0);
      stall    = ($urandom_range(0, 9) < 3);
      br_valid = $urandom_range(0, 1);
      br_tipo  = 3'($urandom_range(0, 7));
      br_pc    = $urandom;
      rs1      = $urandom;
      rs2      = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      imed     = $urandom_range(0, 1) ? $urandom : (32'($urandom_range(0, 512)) - 32'd256);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
